// File: rtl/dma_pkg.sv
// Shared definitions for the dma_responder host-side target.
// Holds the header beat layout (field LSB/MSB positions and the packed
// header struct), the supported opcodes, the responder FSM state type and
// a helper that splits a raw header beat into its fields.
package dma_pkg;

  localparam int unsigned DMA_BEAT_W = 128;

  localparam logic [7:0] OP_WRITE = 8'h03;
  localparam logic [7:0] OP_READ  = 8'h01;

  localparam int unsigned HDR_LOCAL_LSB = 0;
  localparam int unsigned HDR_LOCAL_MSB = 13;
  localparam int unsigned HDR_HOST_LSB  = 14;
  localparam int unsigned HDR_HOST_MSB  = 53;
  localparam int unsigned HDR_LEN_LSB   = 54;
  localparam int unsigned HDR_LEN_MSB   = 69;
  localparam int unsigned HDR_OP_LSB    = 70;
  localparam int unsigned HDR_OP_MSB    = 77;

  typedef struct packed {
    logic [49:0] rsvd;
    logic [7:0]  opcode;
    logic [15:0] len;
    logic [39:0] host_addr;
    logic [13:0] local_addr;
  } dma_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESP,
    ST_HDR,
    ST_WR,
    ST_RD_HDR,
    ST_RD,
    ST_DONE
  } dma_state_t;

  function automatic dma_hdr_t hdr_unpack(input logic [DMA_BEAT_W-1:0] beat);
    dma_hdr_t h;
    h.rsvd       = beat[DMA_BEAT_W-1:HDR_OP_MSB+1];
    h.opcode     = beat[HDR_OP_MSB:HDR_OP_LSB];
    h.len        = beat[HDR_LEN_MSB:HDR_LEN_LSB];
    h.host_addr  = beat[HDR_HOST_MSB:HDR_HOST_LSB];
    h.local_addr = beat[HDR_LOCAL_MSB:HDR_LOCAL_LSB];
    return h;
  endfunction

endpackage

// File: rtl/dma_resp_mem.sv
// Host-memory model for dma_responder: 1R1W synchronous RAM,
// 2^ADDR_W words of DATA_W bits, read data valid one cycle after rd_en.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read
// request; rd_data registered read result (holds when rd_en is low).
module dma_resp_mem #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dma_responder.sv
// Host-side responder for the dma_* interface. Acknowledges a request,
// takes a header beat on the write channel, then either stores a write
// burst into the internal memory or streams a read burst back (header echo
// first, then data) on the read channel.
// Ports: clk, reset_n (async, active low); dma_req/dma_resp request
// handshake; dma_write_valid/data/ready inbound beats; dma_read_valid/
// data/ready outbound beats; busy (not idle), done (burst end pulse),
// err (bad opcode pulse).
module dma_responder
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned RESP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dma_req,
  output logic              dma_resp,
  input  logic              dma_write_valid,
  input  logic [DATA_W-1:0] dma_write_data,
  output logic              dma_write_ready,
  output logic              dma_read_valid,
  output logic [DATA_W-1:0] dma_read_data,
  input  logic              dma_read_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  dma_state_t        state_q, state_d;
  dma_hdr_t          hdr_q, in_hdr, echo_hdr;
  logic [15:0]       resp_cnt_q;
  logic [15:0]       cnt_q;      // write beats accepted / read beats issued
  logic [15:0]       sent_q;     // read beats handed to the controller
  logic [DATA_W-1:0] fifo_q [2];
  logic [1:0]        fifo_cnt_q;
  logic              inflight_q; // memory read issued last cycle
  logic              err_q;
  logic [2:0]        occ, occ_after;
  logic              hdr_hs, wr_hs, bad_op, rd_active;
  logic              pop, pop_fifo, push, issue;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign in_hdr    = hdr_unpack(dma_write_data);
  assign hdr_hs    = (state_q == ST_HDR) && dma_write_valid;
  assign wr_hs     = (state_q == ST_WR) && dma_write_valid;
  assign bad_op    = (in_hdr.opcode != OP_WRITE) && (in_hdr.opcode != OP_READ);
  assign rd_active = (state_q == ST_RD_HDR) || (state_q == ST_RD);

  // Beats owned by the read path: buffered entries plus one in the RAM pipe.
  // The head comes from the buffer when non-empty, else straight from the RAM
  // output; an unconsumed RAM result is always captured into the buffer, so
  // the presented beat stays stable under backpressure. Reads are issued as
  // long as at most two beats would be outstanding after this cycle's pop,
  // which sustains one beat per cycle and starts prefetching under the
  // header echo.
  assign occ       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign pop       = (state_q == ST_RD) && (occ != 3'd0) && dma_read_ready;
  assign pop_fifo  = pop && (fifo_cnt_q != 2'd0);
  assign push      = inflight_q && !(pop && (fifo_cnt_q == 2'd0));
  assign occ_after = occ - {2'b00, pop};
  assign issue     = rd_active && (cnt_q != hdr_q.len) && (occ_after <= 3'd1);
  assign mem_addr  = hdr_q.host_addr[ADDR_W-1:0] + ADDR_W'(cnt_q);

  dma_resp_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_hs),
    .wr_addr (mem_addr),
    .wr_data (dma_write_data),
    .rd_en   (issue),
    .rd_addr (mem_addr),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (dma_req) state_d = ST_RESP;
      ST_RESP:   if (resp_cnt_q == 16'(RESP_CYCLES - 1)) state_d = ST_HDR;
      ST_HDR: begin
        if (dma_write_valid) begin
          if (in_hdr.opcode == OP_WRITE)
            state_d = (in_hdr.len != '0) ? ST_WR : ST_DONE;
          else if (in_hdr.opcode == OP_READ)
            state_d = ST_RD_HDR;
          else
            state_d = ST_IDLE;
        end
      end
      ST_WR:     if (dma_write_valid && (cnt_q == hdr_q.len - 16'd1)) state_d = ST_DONE;
      ST_RD_HDR: if (dma_read_ready) state_d = (hdr_q.len != '0) ? ST_RD : ST_DONE;
      ST_RD:     if (pop && (sent_q == hdr_q.len - 16'd1)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dma_resp        = 1'b0;
    dma_write_ready = 1'b0;
    dma_read_valid  = 1'b0;
    dma_read_data   = '0;
    busy            = (state_q != ST_IDLE);
    done            = (state_q == ST_DONE);
    err             = err_q;
    echo_hdr        = hdr_q;
    echo_hdr.opcode = OP_READ;
    case (state_q)
      ST_RESP:       dma_resp = 1'b1;
      ST_HDR, ST_WR: dma_write_ready = 1'b1;
      ST_RD_HDR: begin
        dma_read_valid = 1'b1;
        dma_read_data  = echo_hdr;
      end
      ST_RD: begin
        if (occ != 3'd0) begin
          dma_read_valid = 1'b1;
          dma_read_data  = (fifo_cnt_q != 2'd0) ? fifo_q[0] : mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_cnt_q <= '0;
      hdr_q      <= '0;
      cnt_q      <= '0;
      sent_q     <= '0;
      fifo_cnt_q <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      resp_cnt_q <= (state_q == ST_RESP) ? resp_cnt_q + 16'd1 : '0;
      err_q      <= hdr_hs && bad_op;
      inflight_q <= issue;
      fifo_cnt_q <= fifo_cnt_q - {1'b0, pop_fifo} + {1'b0, push};
      if (hdr_hs) begin
        hdr_q  <= in_hdr;
        cnt_q  <= '0;
        sent_q <= '0;
      end else if (wr_hs || issue) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (pop) sent_q <= sent_q + 16'd1;
    end
  end

  // Two-entry buffer with head at index 0. A push alongside a buffer pop
  // always lands in slot 0 (only one entry can be present in that case).
  always_ff @(posedge clk) begin
    if (pop_fifo) fifo_q[0] <= fifo_q[1];
    if (push) fifo_q[pop_fifo ? 1'b0 : fifo_cnt_q[0]] <= mem_rdata;
  end

endmodule

// File: tb/tb_dma_responder.sv
module tb_dma_responder;

  localparam int unsigned DEPTH = 1024;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         dma_req = 1'b0;
  logic         dma_resp;
  logic         dma_write_valid = 1'b0;
  logic [127:0] dma_write_data = '0;
  logic         dma_write_ready;
  logic         dma_read_valid;
  logic [127:0] dma_read_data;
  logic         dma_read_ready = 1'b0;
  logic         busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] model_mem [DEPTH];
  logic [127:0] tx_q[$];
  logic [127:0] rx_q[$];

  dma_responder #(
    .ADDR_W      (10),
    .DATA_W      (128),
    .RESP_CYCLES (2)
  ) u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .dma_req         (dma_req),
    .dma_resp        (dma_resp),
    .dma_write_valid (dma_write_valid),
    .dma_write_data  (dma_write_data),
    .dma_write_ready (dma_write_ready),
    .dma_read_valid  (dma_read_valid),
    .dma_read_data   (dma_read_data),
    .dma_read_ready  (dma_read_ready),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] midx(input logic [39:0] host, input int unsigned k);
    int unsigned base;
    base = 32'(host[9:0]);
    return 10'((base + k) % DEPTH);
  endfunction

  function automatic logic [127:0] mk_hdr(input logic [7:0] op, input logic [15:0] len,
                                          input logic [39:0] host);
    logic [127:0] h;
    h = {$urandom, $urandom, $urandom, $urandom};
    h[13:0]  = 14'($urandom);
    h[53:14] = host;
    h[69:54] = len;
    h[77:70] = op;
    return h;
  endfunction

  // Request and count acknowledge cycles; ends on the first cycle after resp drops.
  task automatic open_xfer(input string tag);
    int cyc;
    @(negedge clk);
    dma_req = 1'b1;
    @(negedge clk);
    dma_req = 1'b0;
    cyc = 0;
    while (dma_resp && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_resp_cycles"}, 128'(cyc), 128'(2));
  endtask

  // Send tx_q[0..n-1] with valid held high; any cycle without ready is a gap.
  task automatic send_tx(input string tag, input int n);
    int i, gaps, cyc;
    i = 0; gaps = 0; cyc = 0;
    while (i < n && cyc < 4000) begin
      dma_write_valid = 1'b1;
      dma_write_data  = tx_q[i];
      if (dma_write_ready) i++;
      else gaps++;
      cyc++;
      @(negedge clk);
    end
    dma_write_valid = 1'b0;
    dma_write_data  = '0;
    check({tag, "_beats_sent"}, 128'(i), 128'(n));
    check({tag, "_ready_gaps"}, 128'(gaps), 128'(0));
  endtask

  task automatic recv(input string tag, input int n, input bit rnd, output int cyc);
    bit hold;
    logic [127:0] held;
    rx_q.delete();
    hold = 1'b0; held = '0; cyc = 0;
    while (rx_q.size() < n && cyc < 4000) begin
      dma_read_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold) begin
        check({tag, "_hold_valid"}, 128'(dma_read_valid), 128'(1));
        check({tag, "_hold_data"}, dma_read_data, held);
      end
      hold = 1'b0;
      if (dma_read_valid) begin
        if (dma_read_ready) rx_q.push_back(dma_read_data);
        else begin
          hold = 1'b1;
          held = dma_read_data;
        end
      end
      cyc++;
      @(negedge clk);
    end
    dma_read_ready = 1'b0;
  endtask

  task automatic finish_xfer(input string tag);
    check({tag, "_done"}, 128'(done), 128'(1));
    @(negedge clk);
    check({tag, "_done_once"}, 128'(done), 128'(0));
    check({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  task automatic do_write(input string tag, input logic [39:0] host, input int len, input bit seq);
    open_xfer(tag);
    tx_q.delete();
    tx_q.push_back(mk_hdr(8'h03, 16'(len), host));
    for (int k = 0; k < len; k++)
      tx_q.push_back(seq ? 128'(k + 1) : {$urandom, $urandom, $urandom, $urandom});
    send_tx(tag, len + 1);
    for (int k = 0; k < len; k++) model_mem[midx(host, k)] = tx_q[k + 1];
    finish_xfer(tag);
  endtask

  task automatic do_read(input string tag, input logic [39:0] host, input int len, input bit rnd);
    logic [127:0] hdr;
    int cyc;
    open_xfer(tag);
    hdr = mk_hdr(8'h01, 16'(len), host);
    tx_q.delete();
    tx_q.push_back(hdr);
    send_tx(tag, 1);
    recv(tag, len + 1, rnd, cyc);
    check({tag, "_rx_count"}, 128'(rx_q.size()), 128'(len + 1));
    if (rx_q.size() == len + 1) begin
      check({tag, "_hdr_echo"}, rx_q[0], hdr);
      for (int k = 0; k < len; k++)
        check({tag, "_data"}, rx_q[k + 1], model_mem[midx(host, k)]);
    end
    if (!rnd) check({tag, "_valid_run"}, 128'(cyc), 128'(len + 1));
    finish_xfer(tag);
  endtask

  initial begin
    logic [39:0] host;
    int len;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_flags", 128'({dma_resp, dma_write_ready, dma_read_valid, busy, done, err}), 128'(0));
    check("reset_rdata", dma_read_data, 128'(0));
    reset_n = 1'b1;

    // Write burst of 255 sequential beats, then backdoor view of memory
    do_write("wr255", 40'd119119, 255, 1'b1);
    for (int k = 0; k < 255; k++)
      check("wr255_backdoor", u_dut.u_mem.mem[midx(40'd119119, k)], 128'(k + 1));

    // Read-back at full rate and under random backpressure
    do_read("rd255", 40'd119119, 255, 1'b0);
    do_read("rd255_bp", 40'd119119, 255, 1'b1);

    // Zero length write must not touch memory; zero length read is header only
    do_write("wr0", 40'd119119, 0, 1'b0);
    check("wr0_untouched", u_dut.u_mem.mem[midx(40'd119119, 0)], 128'(1));
    do_read("rd0", 40'd119119, 0, 1'b0);

    // Bad opcode
    open_xfer("badop");
    tx_q.delete();
    tx_q.push_back(mk_hdr(8'h07, 16'd4, 40'd5));
    send_tx("badop", 1);
    check("badop_err", 128'(err), 128'(1));
    check("badop_idle", 128'(busy), 128'(0));
    check("badop_wready", 128'(dma_write_ready), 128'(0));
    @(negedge clk);
    check("badop_err_pulse", 128'(err), 128'(0));
    check("badop_wready_after", 128'(dma_write_ready), 128'(0));

    // Address wrap: prefill 1020..3, overwrite 1022..1, neighbours unchanged
    do_write("wrap_fill", 40'd1020, 8, 1'b0);
    do_write("wrap", 40'd1022, 4, 1'b0);
    for (int k = 0; k < 8; k++)
      check("wrap_backdoor", u_dut.u_mem.mem[midx(40'd1020, k)], model_mem[midx(40'd1020, k)]);
    do_read("wrap_rd", 40'd1020, 8, 1'b1);

    // Reset in the middle of a write burst
    open_xfer("rst");
    host = {8'($urandom), $urandom};
    tx_q.delete();
    tx_q.push_back(mk_hdr(8'h03, 16'd50, host));
    for (int k = 0; k < 50; k++) tx_q.push_back({$urandom, $urandom, $urandom, $urandom});
    send_tx("rst", 11);
    for (int k = 0; k < 10; k++) model_mem[midx(host, k)] = tx_q[k + 1];
    check("rst_busy_before", 128'({busy, dma_write_ready}), 128'(3));
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_flags", 128'({dma_resp, dma_write_ready, dma_read_valid, busy, done, err}), 128'(0));
    check("rst_async_rdata", dma_read_data, 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    do_read("rst_partial", host, 10, 1'b0);
    do_write("rst_after", 40'd300, 8, 1'b0);
    do_read("rst_after_rd", 40'd300, 8, 1'b1);

    // Random bursts
    for (int r = 0; r < 4; r++) begin
      host = {8'($urandom), $urandom};
      len  = int'($urandom_range(1, 40));
      do_write("rnd_wr", host, len, 1'b0);
      do_read("rnd_rd", host, len, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
